// File: rtl/instr_feed_unit.sv
// Instruction feed unit: buffers a short program loaded word-by-word, then
// presents registered opcodes to the processor by fetch address until HLT.
module instr_feed_unit #(
  parameter int unsigned DEPTH      = 16,
  parameter logic [7:0]  NOP_OPCODE = 8'h00,
  parameter logic [7:0]  HLT_OPCODE = 8'hFF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load_valid,
  input  logic [7:0] load_data,
  input  logic       load_last,
  output logic       load_ready,
  input  logic       start,
  input  logic [3:0] program_counter,
  output logic [7:0] opcode,
  output logic       run,
  output logic       halted,
  output logic [4:0] prog_len,
  output logic       err
);

  localparam int unsigned AW = 4;
  localparam int unsigned LW = 5;
  localparam int unsigned DW = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_HALT = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [DW-1:0]   r_mem [DEPTH];
  logic [LW-1:0]   r_wr_ptr;
  logic [LW-1:0]   r_prog_len;
  logic [DW-1:0]   r_opcode;
  logic            r_load_ready;
  logic            r_run;
  logic            r_halted;
  logic            r_err;

  logic [LW-1:0]   w_wr_ptr_nxt;
  logic [LW-1:0]   w_prog_len_nxt;
  logic [DW-1:0]   w_opcode_nxt;
  logic            w_load_ready_nxt;
  logic            w_err_nxt;
  logic            w_mem_we;
  logic [AW-1:0]   w_mem_addr;
  logic            w_accept;
  logic            w_full_wr;
  logic            w_drain;
  logic [DW-1:0]   w_fetch;

  assign w_accept  = load_valid & r_load_ready;
  assign w_full_wr = (r_wr_ptr == LW'(DEPTH - 1));
  // After the last address is written, LOAD lingers one cycle with ready low
  // so a trailing word is dropped instead of starting a new program.
  assign w_drain   = (r_wr_ptr == LW'(DEPTH));
  assign w_fetch   = ({1'b0, program_counter} < r_prog_len) ? r_mem[program_counter]
                                                             : HLT_OPCODE;

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (!load_last) w_state_nxt = ST_LOAD;
        end else if (start && (r_prog_len != '0)) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_LOAD: begin
        if (w_drain || (w_accept && load_last)) w_state_nxt = ST_IDLE;
      end
      ST_RUN: begin
        if (w_fetch == HLT_OPCODE) w_state_nxt = ST_HALT;
      end
      ST_HALT: begin
        if (start) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    w_wr_ptr_nxt   = r_wr_ptr;
    w_prog_len_nxt = r_prog_len;
    w_opcode_nxt   = NOP_OPCODE;
    w_err_nxt      = 1'b0;
    w_mem_we       = 1'b0;
    w_mem_addr     = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_mem_we       = 1'b1;
          w_wr_ptr_nxt   = LW'(1);
          w_prog_len_nxt = load_last ? LW'(1) : '0;
        end else if (start && (r_prog_len == '0)) begin
          w_err_nxt = 1'b1;
        end
      end
      ST_LOAD: begin
        if (w_accept) begin
          w_mem_we     = 1'b1;
          w_mem_addr   = r_wr_ptr[AW-1:0];
          w_wr_ptr_nxt = r_wr_ptr + LW'(1);
          if (load_last || w_full_wr) w_prog_len_nxt = r_wr_ptr + LW'(1);
        end
      end
      ST_RUN:  w_opcode_nxt = w_fetch;
      ST_HALT: w_opcode_nxt = start ? NOP_OPCODE : HLT_OPCODE;
      default: w_opcode_nxt = NOP_OPCODE;
    endcase
    w_load_ready_nxt = (w_state_nxt == ST_IDLE) ||
                       ((w_state_nxt == ST_LOAD) && (w_wr_ptr_nxt < LW'(DEPTH)));
  end

  // Registered outputs and pointers
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr     <= '0;
      r_prog_len   <= '0;
      r_opcode     <= NOP_OPCODE;
      r_load_ready <= 1'b1;
      r_run        <= 1'b0;
      r_halted     <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_wr_ptr     <= w_wr_ptr_nxt;
      r_prog_len   <= w_prog_len_nxt;
      r_opcode     <= w_opcode_nxt;
      r_load_ready <= w_load_ready_nxt;
      r_run        <= (w_state_nxt == ST_RUN);
      r_halted     <= (w_state_nxt == ST_HALT);
      r_err        <= w_err_nxt;
    end
  end

  // Program memory is never cleared; a zero prog_len hides stale contents
  always_ff @(posedge clk) begin
    if (reset && w_mem_we) r_mem[w_mem_addr] <= load_data;
  end

  assign load_ready = r_load_ready;
  assign opcode     = r_opcode;
  assign run        = r_run;
  assign halted     = r_halted;
  assign prog_len   = r_prog_len;
  assign err        = r_err;

endmodule

// File: tb/tb_instr_feed_unit.sv
// Scoreboard bench for instr_feed_unit: a behavioural model queues the expected
// outputs per edge, and a negedge monitor pops and compares them.
module tb_instr_feed_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       load_valid;
  logic [7:0] load_data;
  logic       load_last;
  logic       load_ready;
  logic       start;
  logic [3:0] program_counter;
  logic [7:0] opcode;
  logic       run;
  logic       halted;
  logic [4:0] prog_len;
  logic       err;

  always #5 clk = ~clk;

  instr_feed_unit dut (
    .clk(clk), .reset(reset),
    .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
    .load_ready(load_ready), .start(start), .program_counter(program_counter),
    .opcode(opcode), .run(run), .halted(halted), .prog_len(prog_len), .err(err)
  );

  typedef struct {
    string      tag;
    logic [7:0] op;
    logic       run;
    logic       halted;
    logic [4:0] len;
    logic       ready;
    logic       err;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model: program buffer plus mode, written from the rules directly
  typedef enum {M_IDLE, M_LOAD, M_RUN, M_HALT} mode_t;
  mode_t      m_mode = M_IDLE;
  logic [7:0] m_mem [16];
  int         m_len = 0;
  int         m_ptr = 0;
  logic       m_err = 1'b0;
  logic [7:0] m_op  = 8'h00;

  function automatic bit m_ready();
    return (m_mode == M_IDLE) || (m_mode == M_LOAD && m_ptr < 16);
  endfunction

  task automatic cyc(input bit rst_n, input bit lv, input logic [7:0] ld,
                     input bit ll, input bit st, input logic [3:0] pc,
                     input string tag);
    exp_t       e;
    logic [7:0] v;
    bit         rdy;
    reset = rst_n; load_valid = lv; load_data = ld; load_last = ll;
    start = st; program_counter = pc;
    rdy = m_ready();
    if (!rst_n) begin
      m_mode = M_IDLE; m_op = 8'h00; m_ptr = 0; m_len = 0; m_err = 1'b0;
    end else begin
      m_err = 1'b0;
      case (m_mode)
        M_IDLE: begin
          m_op = 8'h00;
          if (lv && rdy) begin
            m_mem[0] = ld;
            m_ptr = 1;
            if (ll) m_len = 1;
            else begin m_len = 0; m_mode = M_LOAD; end
          end else if (st) begin
            if (m_len > 0) m_mode = M_RUN;
            else m_err = 1'b1;
          end
        end
        M_LOAD: begin
          m_op = 8'h00;
          if (!rdy) m_mode = M_IDLE;
          else if (lv) begin
            m_mem[m_ptr] = ld;
            m_ptr = m_ptr + 1;
            if (ll || m_ptr == 16) m_len = m_ptr;
            if (ll) m_mode = M_IDLE;
          end
        end
        M_RUN: begin
          v = (int'(pc) < m_len) ? m_mem[pc] : 8'hFF;
          m_op = v;
          if (v == 8'hFF) m_mode = M_HALT;
        end
        M_HALT: begin
          if (st) begin m_mode = M_IDLE; m_op = 8'h00; end
          else m_op = 8'hFF;
        end
        default: m_mode = M_IDLE;
      endcase
    end
    e.tag = tag; e.op = m_op; e.run = (m_mode == M_RUN);
    e.halted = (m_mode == M_HALT); e.len = 5'(m_len);
    e.ready = m_ready(); e.err = m_err;
    @(posedge clk);
    sb_q.push_back(e);
    #1;
  endtask

  // Monitor: every edge's result is checked at the following falling edge
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      n_tests++;
      if (opcode !== mon_e.op || run !== mon_e.run || halted !== mon_e.halted ||
          prog_len !== mon_e.len || load_ready !== mon_e.ready || err !== mon_e.err) begin
        n_fail++;
        $display("FAIL %s: got op=%h run=%b halted=%b len=%0d ready=%b err=%b, want op=%h run=%b halted=%b len=%0d ready=%b err=%b",
                 mon_e.tag, opcode, run, halted, prog_len, load_ready, err,
                 mon_e.op, mon_e.run, mon_e.halted, mon_e.len, mon_e.ready, mon_e.err);
      end
    end
  end

  initial begin
    int wait_cnt;
    reset = 1'b0; load_valid = 1'b0; load_data = 8'h00; load_last = 1'b0;
    start = 1'b0; program_counter = 4'h0;

    cyc(0, 0, 8'h00, 0, 0, 4'd0, "reset0");
    cyc(0, 0, 8'h00, 0, 0, 4'd0, "reset1");

    cyc(1, 0, 8'h00, 0, 1, 4'd0, "illegal_start");
    cyc(1, 0, 8'h00, 0, 0, 4'd0, "err_clear");

    cyc(1, 1, 8'h91, 0, 0, 4'd0, "load0");
    cyc(1, 1, 8'h15, 0, 0, 4'd0, "load1");
    cyc(1, 1, 8'hFF, 1, 0, 4'd0, "load2_last");
    cyc(1, 0, 8'h00, 0, 1, 4'd0, "start");
    cyc(1, 0, 8'h00, 0, 0, 4'd0, "fetch0");
    cyc(1, 0, 8'h00, 0, 0, 4'd1, "fetch1");
    cyc(1, 0, 8'h00, 0, 0, 4'd2, "fetch2_halt");
    cyc(1, 0, 8'h00, 0, 0, 4'd3, "halt_hold");

    cyc(1, 0, 8'h00, 0, 1, 4'd0, "halt_exit");
    cyc(1, 0, 8'h00, 0, 1, 4'd0, "rerun");
    for (int i = 0; i < 3; i++) cyc(1, 0, 8'h00, 0, 0, 4'(i), "rerun_fetch");
    cyc(1, 0, 8'h00, 0, 1, 4'd0, "halt_exit2");
    cyc(1, 1, 8'h01, 0, 1, 4'd0, "start_vs_load");
    cyc(1, 1, 8'h02, 1, 1, 4'd0, "load_end_start_ignored");

    cyc(1, 0, 8'h00, 0, 1, 4'd0, "start2");
    cyc(1, 0, 8'h00, 0, 0, 4'd5, "oob_fetch");
    cyc(1, 0, 8'h00, 0, 1, 4'd0, "halt_exit3");

    for (int i = 0; i < 17; i++) cyc(1, 1, 8'(8'h40 + i), 0, 0, 4'd0, "fill");
    cyc(1, 0, 8'h00, 0, 0, 4'd0, "fill_done");
    cyc(1, 0, 8'h00, 0, 1, 4'd0, "full_start");
    for (int i = 0; i < 16; i++) cyc(1, 0, 8'h00, 0, 0, 4'(i), "full_fetch");

    cyc(1, 0, 8'h00, 0, 0, 4'd0, "pre_rst_fetch");
    cyc(0, 0, 8'h00, 0, 0, 4'd1, "rst_run");
    cyc(1, 0, 8'h00, 0, 0, 4'd1, "post_rst");
    cyc(1, 0, 8'h00, 0, 1, 4'd0, "post_rst_start");
    cyc(1, 0, 8'h00, 0, 0, 4'd0, "post_rst_idle");

    for (int i = 0; i < 3000; i++) begin
      bit         r_rst, r_lv, r_ll, r_st;
      logic [7:0] r_ld;
      logic [3:0] r_pc;
      r_rst = ($urandom_range(0, 99) != 0);
      r_lv  = ($urandom_range(0, 99) < 40);
      r_ld  = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
      r_ll  = ($urandom_range(0, 3) == 0);
      r_st  = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 9) < 7 && m_len > 0) r_pc = 4'($urandom_range(0, m_len - 1));
      else r_pc = 4'($urandom);
      cyc(r_rst, r_lv, r_ld, r_ll, r_st, r_pc, "random");
    end

    wait_cnt = 0;
    while (sb_q.size() > 0 && wait_cnt < 5) begin
      @(negedge clk);
      #1;
      wait_cnt++;
    end
    if (sb_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expected entries left unchecked, want 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
